reg_bank_2r1w: RTL and testbench

//  Parametrised register bank for the Mini-CPU datapath: two read ports (addr1/addr2), one write port (dest).

---
 rtl/mini_cpu_pkg.sv | 7 +
 rtl/reg_bank_clr_seq.sv | 36 +++
 rtl/reg_bank_2r1w.sv | 71 +++++++
 tb/tb_reg_bank_2r1w.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: shared Mini-CPU widths and clear-sweep state encoding
package mini_cpu_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;
endpackage

// File: rtl/reg_bank_clr_seq.sv
// reg_bank_clr_seq: clear-sweep FSM and pointer; ports clk, rst, clr in; busy, clr_we, clr_addr out
module reg_bank_clr_seq
    import mini_cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    logic              state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              last;
    assign last = &ptr;
    // ptr parks at the last entry so the sweep can never roll into a second pass
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= (state == ST_IDLE) ? '0 : (last ? ptr : ptr + 1'b1);
        end
    end
    always_comb begin
        state_nx = (state == ST_IDLE) ? (clr ? ST_CLEAR : ST_IDLE) : (last ? ST_IDLE : ST_CLEAR);
    end
    always_comb begin
        busy     = (state == ST_CLEAR);
        clr_we   = busy;
        clr_addr = ptr;
    end
endmodule

// File: rtl/reg_bank_2r1w.sv
// reg_bank_2r1w: 2-read/1-write register bank with registered reads, bypass, hard-zero entry and clear sweep
// ports: clk, rst; write we/dest/data; read re/addr1/addr2 -> q1/q2/rd_valid; clr request -> busy
module reg_bank_2r1w
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] data,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              clr,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic              rd_valid,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic              clr_we, wr_en, rd_go;
    logic [ADDR_W-1:0] clr_addr, wr_addr;
    logic [DATA_W-1:0] wr_data, rd1, rd2;

    reg_bank_clr_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // a hard-zero entry short-circuits before the bypass, so a write to 0 never leaks into a read
    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        return (ZERO_REG && a == '0) ? '0 : (BYPASS && we && a == dest) ? data : ram[a];
    endfunction

    always_comb begin
        wr_en   = clr_we | (we & ~(ZERO_REG && dest == '0));
        wr_addr = clr_we ? clr_addr : dest;
        wr_data = clr_we ? '0 : data;
        rd_go   = re & ~busy;
        rd1     = rd_word(addr1);
        rd2     = rd_word(addr2);
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1       <= '0;
            q2       <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                q1 <= rd1;
                q2 <= rd2;
            end
        end
    end
endmodule

// File: tb/tb_reg_bank_2r1w.sv
// tb_reg_bank_2r1w: directed table-driven bench for a default bank and a ZERO_REG=1/BYPASS=0 bank
module tb_reg_bank_2r1w;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0, clr = 1'b0;
    logic [3:0]  dest = '0, a1 = '0, a2 = '0;
    logic [15:0] data = '0;
    logic [15:0] q1, q2, zq1, zq2;
    logic        rv, busy, zrv, zbusy;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    reg_bank_2r1w dut (
        .clk(clk), .rst(rst), .we(we), .dest(dest), .data(data), .re(re),
        .addr1(a1), .addr2(a2), .clr(clr), .q1(q1), .q2(q2), .rd_valid(rv), .busy(busy)
    );

    reg_bank_2r1w #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_z (
        .clk(clk), .rst(rst), .we(we), .dest(dest), .data(data), .re(re),
        .addr1(a1), .addr2(a2), .clr(clr), .q1(zq1), .q2(zq2), .rd_valid(zrv), .busy(zbusy)
    );

    typedef struct {
        logic        we;
        logic [3:0]  dest;
        logic [15:0] data;
        logic        re;
        logic [3:0]  a1, a2;
        logic        v;
        logic [15:0] q1, q2, zq1, zq2;
    } vec_t;
    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // called right after the edge that starts a sweep; counts busy cycles of both banks
    task automatic sweep(input string nm, input logic noisy);
        int n = 1, zn = 1, bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (noisy) begin
                we = 1'b1; dest = i[3:0]; data = 16'hDEAD;
                re = 1'b1; a1 = i[3:0]; a2 = ~i[3:0]; clr = 1'b1;
            end
            step;
            if (busy) n++;
            if (zbusy) zn++;
            if (rv || zrv) bad++;
            if (!busy && !zbusy) break;
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;
        chk({nm, " busy_cycles"}, n, 16);
        chk({nm, " z_busy_cycles"}, zn, 16);
        chk({nm, " rd_valid_while_busy"}, bad, 0);
    endtask

    task automatic read_all(input string nm);
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; a1 = i[3:0]; a2 = 4'(15 - i);
            step;
            chk({nm, " q1"}, q1, 0);
            chk({nm, " q2"}, q2, 0);
            chk({nm, " zq1"}, zq1, 0);
            chk({nm, " zq2"}, zq2, 0);
            chk({nm, " rd_valid"}, rv & zrv, 1);
        end
        re = 1'b0;
    endtask

    initial begin
        //          we dest data      re a1 a2 v  q1        q2        zq1       zq2
        vt[0]  = '{1, 3, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vt[1]  = '{0, 0, 16'h0000, 1, 3, 3, 1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vt[2]  = '{0, 0, 16'h0000, 0, 3, 3, 0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vt[3]  = '{1, 5, 16'h1111, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vt[4]  = '{1, 4, 16'h4444, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vt[5]  = '{1, 5, 16'h2222, 1, 5, 4, 1, 16'h2222, 16'h4444, 16'h1111, 16'h4444};
        vt[6]  = '{0, 0, 16'h0000, 1, 5, 5, 1, 16'h2222, 16'h2222, 16'h2222, 16'h2222};
        vt[7]  = '{1, 0, 16'hFFFF, 1, 0, 3, 1, 16'hFFFF, 16'hBEEF, 16'h0000, 16'hBEEF};
        vt[8]  = '{0, 0, 16'h0000, 1, 0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
        vt[9]  = '{1, 7, 16'h1234, 1, 7, 6, 1, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
        vt[10] = '{0, 0, 16'h0000, 1, 7, 3, 1, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vt[11] = '{1, 6, 16'h00FF, 0, 0, 0, 0, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vt[12] = '{1, 9, 16'h0009, 1, 6, 9, 1, 16'h00FF, 16'h0009, 16'h00FF, 16'h0000};

        step;
        chk("reset q1", q1, 0);
        chk("reset q2", q2, 0);
        chk("reset rd_valid", rv, 0);
        chk("reset busy", busy & zbusy, 1);
        rst = 1'b0;
        sweep("reset_sweep", 1'b0);
        read_all("after_reset");

        for (int i = 0; i < 13; i++) begin
            we = vt[i].we; dest = vt[i].dest; data = vt[i].data;
            re = vt[i].re; a1 = vt[i].a1; a2 = vt[i].a2;
            step;
            chk($sformatf("vec%0d q1", i), q1, vt[i].q1);
            chk($sformatf("vec%0d q2", i), q2, vt[i].q2);
            chk($sformatf("vec%0d zq1", i), zq1, vt[i].zq1);
            chk($sformatf("vec%0d zq2", i), zq2, vt[i].zq2);
            chk($sformatf("vec%0d rd_valid", i), rv, vt[i].v);
            chk($sformatf("vec%0d z_rd_valid", i), zrv, vt[i].v);
        end
        we = 1'b0; re = 1'b0;

        for (int i = 0; i < 16; i++) begin
            we = 1'b1; dest = i[3:0]; data = 16'hA5A5;
            step;
        end
        we = 1'b0;
        re = 1'b1; a1 = 4'd0; a2 = 4'd15;
        step;
        re = 1'b0;
        chk("fill q1", q1, 16'hA5A5);
        chk("fill q2", q2, 16'hA5A5);
        chk("fill zq1", zq1, 16'h0000);
        chk("fill zq2", zq2, 16'hA5A5);
        clr = 1'b1;
        step;
        clr = 1'b0;
        chk("clr busy", busy & zbusy, 1);
        sweep("clr_sweep", 1'b1);
        chk("clr hold q1", q1, 16'hA5A5);
        chk("clr hold zq1", zq1, 16'h0000);
        read_all("after_clr");

        clr = 1'b1;
        step;
        clr = 1'b0;
        re = 1'b1; a1 = 4'd2; a2 = 4'd3;
        for (int i = 0; i < 6; i++) step;
        chk("mid_sweep busy", busy & zbusy, 1);
        chk("mid_sweep rd_valid", rv | zrv, 0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("rst_mid busy", busy & zbusy, 1);
        chk("rst_mid rd_valid", rv | zrv, 0);
        sweep("rst_mid_sweep", 1'b1);
        read_all("after_rst_mid");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
